// File: rtl/sound_player.sv
// Pong audio back end: turns the synchronized channel/sound request into
// square-wave tones on the left/right audio pins, with a two-tone goal warble.
module sound_player #(
    parameter int PING_HALF    = 26042,
    parameter int PONG_HALF    = 13021,
    parameter int GOAL_LO_HALF = 50000,
    parameter int GOAL_HI_HALF = 25000,
    parameter int GOAL_STEP    = 2500000,
    parameter int CNT_W        = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] channel,
    input  logic [1:0] sound,
    output logic       audio_left,
    output logic       audio_right,
    output logic       busy
);
    // state  | meaning
    // S_IDLE | no request, outputs silent
    // S_PLAY | tone running on cur_ch with cur_snd
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_PLAY = 1'b1;

    localparam int STEP_W = $clog2(GOAL_STEP + 1);

    logic [3:0]        sync1_q, sync1_d;
    logic [3:0]        sync2_q, sync2_d;
    logic [0:0]        state_q, state_d;
    logic [1:0]        cur_ch_q, cur_ch_d;
    logic [1:0]        cur_snd_q, cur_snd_d;
    logic              phase_q, phase_d;
    logic              hi_sel_q, hi_sel_d;
    logic [CNT_W-1:0]  half_q, half_d;
    logic [STEP_W-1:0] step_q, step_d;

    logic [1:0] ch_s;
    logic [1:0] snd_s;
    logic       req;

    function automatic logic [CNT_W-1:0] half_m1(input logic [1:0] snd, input logic hi);
        logic [CNT_W-1:0] h;
        case (snd)
            2'd1:    h = CNT_W'(PING_HALF - 1);
            2'd2:    h = CNT_W'(PONG_HALF - 1);
            2'd3:    h = hi ? CNT_W'(GOAL_HI_HALF - 1) : CNT_W'(GOAL_LO_HALF - 1);
            default: h = '0;
        endcase
        return h;
    endfunction

    assign ch_s  = sync2_q[3:2];
    assign snd_s = sync2_q[1:0];
    assign req   = (ch_s != 2'd0) && (snd_s != 2'd0);

    always_comb begin
        sync1_d   = {channel, sound};
        sync2_d   = sync1_q;
        state_d   = state_q;
        cur_ch_d  = cur_ch_q;
        cur_snd_d = cur_snd_q;
        phase_d   = phase_q;
        hi_sel_d  = hi_sel_q;
        half_d    = half_q;
        step_d    = step_q;

        // Entry and restart share one load; a differing request preempts the tone.
        if (req && (state_q == S_IDLE || {ch_s, snd_s} != {cur_ch_q, cur_snd_q})) begin
            state_d   = S_PLAY;
            cur_ch_d  = ch_s;
            cur_snd_d = snd_s;
            phase_d   = 1'b1;
            hi_sel_d  = 1'b0;
            half_d    = half_m1(snd_s, 1'b0);
            step_d    = STEP_W'(GOAL_STEP - 1);
        end else if (state_q == S_PLAY) begin
            if (!req) begin
                state_d = S_IDLE;
                phase_d = 1'b0;
            end else begin
                // Reload uses the pre-toggle hi_sel so no half-period is cut short.
                if (half_q == '0) begin
                    phase_d = ~phase_q;
                    half_d  = half_m1(cur_snd_q, hi_sel_q);
                end else begin
                    half_d = half_q - 1'b1;
                end
                if (cur_snd_q == 2'd3) begin
                    if (step_q == '0) begin
                        hi_sel_d = ~hi_sel_q;
                        step_d   = STEP_W'(GOAL_STEP - 1);
                    end else begin
                        step_d = step_q - 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            state_q   <= S_IDLE;
            cur_ch_q  <= '0;
            cur_snd_q <= '0;
            phase_q   <= 1'b0;
            hi_sel_q  <= 1'b0;
            half_q    <= '0;
            step_q    <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            cur_ch_q  <= cur_ch_d;
            cur_snd_q <= cur_snd_d;
            phase_q   <= phase_d;
            hi_sel_q  <= hi_sel_d;
            half_q    <= half_d;
            step_q    <= step_d;
        end
    end

    assign audio_left  = phase_q & cur_ch_q[1];
    assign audio_right = phase_q & cur_ch_q[0];
    assign busy        = (state_q == S_PLAY);

endmodule

// File: tb/tb_sound_player.sv
// Scoreboard bench for sound_player: stimulus queues per-edge expected outputs,
// a monitor checks {busy, audio_left, audio_right} 1 time unit after each rising edge.
module tb_sound_player;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] channel = 2'd3;
    logic [1:0] sound = 2'd1;
    logic       audio_left, audio_right, busy;

    typedef struct {
        int         e;
        logic [2:0] v;
    } exp_t;

    exp_t q[$];
    int   edge_n = 0;
    int   n_vec  = 0;
    int   n_bad  = 0;
    int   hv[16];

    always #5 clk = ~clk;

    sound_player #(
        .PING_HALF(4),
        .PONG_HALF(2),
        .GOAL_LO_HALF(6),
        .GOAL_HI_HALF(3),
        .GOAL_STEP(20),
        .CNT_W(17)
    ) dut (
        .clk(clk),
        .reset(reset),
        .channel(channel),
        .sound(sound),
        .audio_left(audio_left),
        .audio_right(audio_right),
        .busy(busy)
    );

    always begin
        exp_t x;
        @(posedge clk);
        #1;
        edge_n++;
        while (q.size() > 0 && q[0].e <= edge_n) begin
            x = q.pop_front();
            n_vec++;
            if (x.e != edge_n || {busy, audio_left, audio_right} !== x.v) begin
                n_bad++;
                $display("FAIL outputs edge %0d (tag %0d): {busy,left,right}=%b expected %b",
                         edge_n, x.e, {busy, audio_left, audio_right}, x.v);
            end
        end
    end

    // Phase at cycle i of a tone whose successive half-periods are listed in hv.
    function automatic logic ph(input int i);
        int acc = 0;
        for (int k = 0; k < 16; k++) begin
            acc += hv[k];
            if (i < acc) return (k % 2) == 0;
        end
        return 1'b0;
    endfunction

    function automatic void push(input int e, input logic [2:0] v);
        exp_t x;
        x.e = e;
        x.v = v;
        q.push_back(x);
    endfunction

    // Called at a falling edge; the new request is visible on the outputs 3 edges later.
    task automatic seg(input logic [1:0] ch, input logic [1:0] snd, input int len, input int nwait);
        int   t0;
        logic on, p;
        t0 = edge_n;
        channel = ch;
        sound   = snd;
        on = (ch != 2'd0) && (snd != 2'd0);
        for (int i = 0; i < len; i++) begin
            p = on & ph(i);
            push(t0 + 3 + i, {on, p & ch[1], p & ch[0]});
        end
        repeat (nwait) @(negedge clk);
    endtask

    initial begin
        int r;
        // Reset held 3 edges with a request present, then 2 sync edges of silence.
        for (int e = 1; e <= 5; e++) push(e, 3'b000);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        hv = '{default: 4};
        seg(2'd3, 2'd1, 12, 12);
        seg(2'd0, 2'd1, 6, 6);
        seg(2'd1, 2'd1, 40, 40);
        seg(2'd0, 2'd1, 6, 6);
        hv = '{default: 2};
        seg(2'd2, 2'd2, 5, 5);
        hv = '{default: 4};
        seg(2'd3, 2'd1, 12, 12);
        seg(2'd0, 2'd0, 6, 6);
        // Goal: 6-cycle halves until the first reload after cycle 20, 3 until after 40,
        // and the reload at cycle 60 coincides with the step toggle and stays at 6.
        hv = '{6, 6, 6, 6, 3, 3, 3, 3, 3, 3, 6, 6, 6, 6, 3, 3};
        seg(2'd3, 2'd3, 70, 70);
        seg(2'd1, 2'd0, 14, 14);
        seg(2'd3, 2'd3, 30, 32);
        // Reset mid-goal while hi_sel is high; the restarted goal must begin low (6).
        reset = 1'b1;
        r = edge_n;
        for (int e = 1; e <= 4; e++) push(r + e, 3'b000);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seg(2'd3, 2'd3, 30, 30);
        repeat (4) @(negedge clk);
        if (q.size() != 0) begin
            $display("FAIL drain: %0d expected vectors unchecked, required 0", q.size());
            n_vec += q.size();
            n_bad += q.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/sound_player.md
# sound_player

Audio back end for the Pong game: consumes the `channel`/`sound` request pair produced by the game-dynamics block and drives two 1-bit square-wave audio pins (left/right). Ping and pong are fixed tones. Goal is a two-tone warble. Each tone plays on the requested channel(s) for as long as the request stays non-`none`; event duration is owned by the dynamics block. Sits between the game core and the board's audio output pins (PWM/RC filter or piezo).

## Interface

Parameters:
- `PING_HALF`, 26042: half-period of the ping tone in `clk` cycles (480 Hz at 25 MHz).
- `PONG_HALF`, 13021: half-period of the pong tone (960 Hz).
- `GOAL_LO_HALF`, 50000: goal low-tone half-period (250 Hz).
- `GOAL_HI_HALF`, 25000: goal high-tone half-period (500 Hz).
- `GOAL_STEP`, 2500000: cycles per goal tone alternation (100 ms).
- `CNT_W`, 17: half-period counter width. All `*_HALF` values are ≥2 and < 2^CNT_W.

Ports:
- `clk` input 1: system clock; the only clock.
- `reset` input 1: synchronous, active-high.
- `channel` input 2: 0 none, 1 right, 2 left, 3 both. Driven from the slow dynamic-clock domain.
- `sound` input 2: 0 silent, 1 ping, 2 pong, 3 goal.
- `audio_left` output 1: left square wave.
- `audio_right` output 1: right square wave.
- `busy` output 1: high while a tone is playing.

## Operation

- Input sync: `channel` and `sound` pass through a 2-flop synchronizer (4 bits), giving `ch_s` and `snd_s`. Inputs are quasi-static, so no further CDC handling is used.
- Request valid: `req = (ch_s != 0) && (snd_s != 0)`.
- FSM states are IDLE and PLAY.
  - IDLE → PLAY when `req`. The block latches `cur_ch = ch_s` and `cur_snd = snd_s`, sets `phase = 1`, sets `hi_sel = 0`, loads the half counter with `half(cur_snd) − 1`, and loads the step counter with `GOAL_STEP − 1`.
  - PLAY → IDLE when `!req`. It clears `phase`. `cur_ch` keeps its value but is irrelevant because `phase = 0`.
  - PLAY with `req` and (`ch_s`, `snd_s`) ≠ (`cur_ch`, `cur_snd`) is a restart. It performs the same load as IDLE entry. A new event preempts the current one.
- Half-period selection:
  - ping → `PING_HALF`.
  - pong → `PONG_HALF`.
  - goal → `GOAL_HI_HALF` if `hi_sel`, else `GOAL_LO_HALF`.
- Tone generation in PLAY:
  - The half counter decrements each cycle.
  - At 0 it toggles `phase` and reloads `half(cur_snd) − 1`, using the current `hi_sel`.
- Goal warble:
  - The step counter decrements each cycle in PLAY while `cur_snd == 3`.
  - At 0 it toggles `hi_sel` and reloads `GOAL_STEP − 1`.
  - The new half-period takes effect at the next half-counter reload. The current half-period is never truncated.
- Outputs: `audio_left = phase & cur_ch[1]`, `audio_right = phase & cur_ch[0]`, `busy = (state == PLAY)`. These are pure ANDs of registers, so there are no combinational paths from the inputs.
- Reset: state IDLE; sync flops, `cur_ch`, `cur_snd`, `phase`, `hi_sel` and both counters all 0. Outputs are therefore `audio_left = 0`, `audio_right = 0`, `busy = 0`.
- Reset mid-tone: outputs are 0 after the reset edge. A `req` still present after reset is released restarts from the synchronizer (3-edge latency).

## Timing

- Latency: if the input changes before edge 0, `ch_s`/`snd_s` update at edge 1 and PLAY is entered at edge 2. The output is high from edge 2.
- Waveform: exactly `HALF` cycles high, then `HALF` cycles low, for a period of `2·HALF`. The first half-period is high.
- Stop: `channel → none` before edge 0 means the output is low from edge 2, mid-period or not.
- Restart: also takes effect at edge 2. Phase is forced high and the counter is reloaded, with no partial low period inserted.
- Goal: `hi_sel` first toggles `GOAL_STEP` cycles after PLAY entry.
- Simultaneous half-counter and step-counter expiry: the half reload uses the pre-toggle `hi_sel`.
- `sound == 0` with `channel != 0` is silence. It does not enter PLAY; if already in PLAY, it returns to IDLE.

## Test plan

Bench parameters: `PING_HALF=4`, `PONG_HALF=2`, `GOAL_LO_HALF=6`, `GOAL_HI_HALF=3`, `GOAL_STEP=20`.

1. Reset held 3 cycles with `channel=3`, `sound=1` → all outputs 0 throughout. After release, `busy` rises on the 3rd edge.
2. `channel=1`, `sound=1` for 40 cycles → `audio_right` is a 4-high/4-low square starting 2 edges after the change; `audio_left` stays 0. `channel=0` → both outputs 0 and `busy=0` within 2 edges.
3. `channel=2`, `sound=2` → `audio_left` toggles every 2 cycles. Switching to `channel=3`, `sound=1` mid-high phase → both outputs high for 4 cycles from the restart edge, then normal 4/4.
4. `channel=3`, `sound=3` for 60 cycles → both outputs show half-periods of 6 until the first reload after cycle 20, then 3. After cycle 40 they return to 6, and no half-period is shortened.
5. `channel=1`, `sound=0` → `busy` stays 0 and outputs stay 0.
6. Reset asserted mid-goal tone → outputs 0 at the reset edge, and `hi_sel` starts low again after restart.
